uart_tx_port: RTL and testbench

- Memory-mapped serial output device that responds to CPU data-bus writes at the console address.
- Replaces the simulation-only character print with a real 8N1 UART transmitter.
- Sits beside the main memory on the same addr/value/write bus. Its value_o is zero unless its status register was read, so it can be OR-merged with the memory read data.
- Buffers characters in a small FIFO so the CPU can issue back-to-back stores without stalling.

---
 rtl/uart_tx_port_pkg.sv | 36 +++
 rtl/uart_tx_port_fifo.sv | 57 +++++
 rtl/uart_tx_port.sv | 151 +++++++++++++++
 tb/tb_uart_tx_port.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the console UART: FSM encoding, status bit layout and default bus addresses.
// The default addresses are also used by the CPU top level when it places this port on the bus.
package uart_defs;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_ACTIVE    = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [19:0] DEF_DATA_ADDR   = 20'h3fff;
  localparam logic [19:0] DEF_STATUS_ADDR = 20'h3ffe;

  function automatic logic [7:0] pack_status(
    input logic       empty,
    input logic       full,
    input logic       active,
    input logic       ovf,
    input logic [3:0] count
  );
    logic [7:0] s;
    s                     = '0;
    s[ST_EMPTY]           = empty;
    s[ST_FULL]            = full;
    s[ST_ACTIVE]          = active;
    s[ST_OVF]             = ovf;
    s[ST_COUNT_LSB +: 4]  = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Circular-buffer FIFO with a separate occupancy counter.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Bus-mapped 8N1 console transmitter: data register pushes into a FIFO, status register is readable.
// value_o is zero unless the previous cycle addressed the status register, so it can be OR-merged.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte at wrap for back-to-back frames
module uart_tx_port
  import uart_defs::*;
#(
  parameter int                    WORD_SIZE    = 20,
  parameter logic [WORD_SIZE-1:0]  DATA_ADDR    = WORD_SIZE'(DEF_DATA_ADDR),
  parameter logic [WORD_SIZE-1:0]  STATUS_ADDR  = WORD_SIZE'(DEF_STATUS_ADDR),
  parameter int                    CLKS_PER_BIT = 16,
  parameter int                    FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] value_i,
  input  logic                 write_i,
  output logic [WORD_SIZE-1:0] value_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam int             CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]           r_state;
  logic [BW-1:0]        r_baud;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_ovf;
  logic [WORD_SIZE-1:0] r_value;

  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [7:0]           w_fifo_data;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wrap;
  logic                 w_stat_rd;
  logic                 w_ovf_evt;
  logic [7:0]           w_status;
  logic                 w_unused;

  assign w_unused  = ^value_i[WORD_SIZE-1:8];
  assign w_push    = write_i && (addr_i == DATA_ADDR);
  assign w_stat_rd = (addr_i == STATUS_ADDR);
  assign w_wrap    = (r_baud == BAUD_LAST);
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_wrap));
  assign w_ovf_evt = w_push && w_full && !w_pop;
  assign w_status  = pack_status(w_empty, w_full, r_state != S_IDLE, r_ovf, 4'(w_count));

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (value_i[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          if (w_wrap) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_data;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
      endcase
    end
  end

  // A status read clears overflow, but an overflow on the same edge keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf   <= 1'b0;
      r_value <= '0;
    end else begin
      r_ovf   <= (r_ovf && !w_stat_rd) || w_ovf_evt;
      r_value <= w_stat_rd ? WORD_SIZE'(w_status) : '0;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (r_state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = r_shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign value_o = r_value;
  assign busy_o  = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a queue-based line model checked every cycle, plus directed scenarios
// with literal expectations and a randomized bus phase.
module tb_uart_tx_port;

  localparam int WS = 20;
  localparam int C  = 4;
  localparam int D  = 8;
  localparam int FRAME = 10 * C;
  localparam logic [WS-1:0] A_DATA = 20'h3fff;
  localparam logic [WS-1:0] A_STAT = 20'h3ffe;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WS-1:0] addr_i = '0;
  logic [WS-1:0] value_i = '0;
  logic          write_i = 1'b0;
  logic [WS-1:0] value_o;
  logic          tx_o;
  logic          busy_o;

  uart_tx_port #(
    .WORD_SIZE    (WS),
    .DATA_ADDR    (A_DATA),
    .STATUS_ADDR  (A_STAT),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr_i  (addr_i),
    .value_i (value_i),
    .write_i (write_i),
    .value_o (value_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Line model: queued bytes, frame-in-progress flag and elapsed cycles within the frame.
  byte unsigned  mq[$];
  bit            m_ovf = 1'b0;
  bit            m_act = 1'b0;
  int            m_el  = 0;
  logic [7:0]    m_cur = '0;
  logic [WS-1:0] m_vo  = '0;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin : model
    int         n;
    bit         pop;
    bit         novf;
    logic [7:0] st;
    if (reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_act   = 1'b0;
      m_el    = 0;
      m_vo    = '0;
      m_valid = 1'b1;
    end else begin
      n    = mq.size();
      st   = {4'(n), m_ovf, m_act, (n == D), (n == 0)};
      m_vo = (addr_i == A_STAT) ? WS'(st) : '0;
      pop  = (n > 0) && (!m_act || m_el == FRAME - 1);
      if (pop) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_el  = 0;
      end else if (m_act) begin
        if (m_el == FRAME - 1) m_act = 1'b0;
        else m_el++;
      end
      novf = 1'b0;
      if (write_i && addr_i == A_DATA) begin
        if (n < D || pop) mq.push_back(value_i[7:0]);
        else novf = 1'b1;
      end
      m_ovf = (m_ovf && addr_i != A_STAT) || novf;
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_act) return 1'b1;
    b = m_el / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_tx_o", 32'(tx_o), 32'(exp_tx()));
      check("model_busy_o", 32'(busy_o), 32'((mq.size() > 0) || m_act));
      check("model_value_o", 32'(value_o), 32'(m_vo));
    end
  end

  task automatic drive(input logic [WS-1:0] a, input logic [WS-1:0] v, input logic w);
    @(negedge clk);
    reset   = 1'b0;
    addr_i  = a;
    value_i = v;
    write_i = w;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int cnt;
    cnt = 0;
    while (busy_o && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    check(name, 32'(busy_o), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [9:0]  fr1;
    logic [19:0] fr2;
    int          lows;
    int          r;
    int          wp;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx_o), 32'(1));
    check("reset_busy", 32'(busy_o), 32'(0));
    check("reset_value", 32'(value_o), 32'(0));

    // single 'h41 frame
    fr1 = {1'b1, 8'h41, 1'b0};
    drive(A_DATA, 20'h41, 1'b1);
    drive('0, '0, 1'b0);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check("t1_frame_bit", 32'(tx_o), 32'(fr1[k / C]));
    end
    check("t1_busy_last", 32'(busy_o), 32'(1));
    @(negedge clk);
    check("t1_busy_drop", 32'(busy_o), 32'(0));
    check("t1_model_idle", 32'(m_act), 32'(0));

    // back-to-back 'h55, 'hAA
    fr2 = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    drive(A_DATA, 20'h55, 1'b1);
    drive(A_DATA, 20'hAA, 1'b1);
    drive('0, '0, 1'b0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k > 0) @(negedge clk);
      check("t2_frame_bit", 32'(tx_o), 32'(fr2[k / C]));
    end
    @(negedge clk);
    check("t2_busy_drop", 32'(busy_o), 32'(0));

    // ten writes: one popped, eight queued, last dropped
    for (int i = 0; i < 10; i++) drive(A_DATA, WS'(8'h30 + i), 1'b1);
    drive(A_STAT, '0, 1'b0);
    drive(A_STAT, '0, 1'b0);
    check("t3_status_ovf", 32'(value_o), 32'h8E);
    check("t3_model_status", 32'(m_vo), 32'h8E);
    drive('0, '0, 1'b0);
    check("t3_status_cleared", 32'(value_o), 32'h86);
    check("t3_model_cleared", 32'(m_vo), 32'h86);
    wait_idle("t3_drain", 10 * FRAME + 20);

    // status register at idle, writes to non-data addresses
    drive(A_STAT, '0, 1'b0);
    drive(A_STAT, '0, 1'b0);
    check("t4_idle_status", 32'(value_o), 32'h001);
    drive(A_STAT, 20'h7A, 1'b1);
    drive(A_STAT, '0, 1'b0);
    check("t4_stat_write_value", 32'(value_o), 32'h001);
    check("t4_stat_write_busy", 32'(busy_o), 32'(0));
    drive(20'h3ffd, 20'h55, 1'b1);
    drive(20'h00010, '0, 1'b0);
    check("t4_other_addr_value", 32'(value_o), 32'(0));
    check("t4_other_write_busy", 32'(busy_o), 32'(0));
    drive(A_STAT, '0, 1'b0);
    drive('0, '0, 1'b0);
    check("t4_fifo_unchanged", 32'(value_o), 32'h001);

    // reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) drive(A_DATA, WS'(8'hA1 + i), 1'b1);
    drive('0, '0, 1'b0);
    repeat (12) @(negedge clk);
    reset   = 1'b1;
    @(negedge clk);
    check("t5_reset_tx", 32'(tx_o), 32'(1));
    check("t5_reset_busy", 32'(busy_o), 32'(0));
    drive(A_STAT, '0, 1'b0);
    drive('0, '0, 1'b0);
    check("t5_status_after_reset", 32'(value_o), 32'h001);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
    end
    check("t5_no_frames_after_reset", 32'(lows), 32'(0));

    // randomized bus traffic in alternating heavy/light write phases
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        reset   = 1'b1;
        write_i = 1'b0;
        addr_i  = '0;
      end else begin
        wp = (((i / 300) % 2) != 0) ? 40 : 3;
        r  = $urandom_range(0, 99);
        if (r < wp)            drive(A_DATA, WS'($urandom), 1'b1);
        else if (r < wp + 15)  drive(A_STAT, '0, 1'b0);
        else if (r < wp + 17)  drive(A_STAT, WS'($urandom), 1'b1);
        else if (r < wp + 20)  drive(WS'($urandom), WS'($urandom), 1'b1);
        else                   drive(WS'($urandom), WS'($urandom), 1'b0);
      end
    end
    drive('0, '0, 1'b0);
    wait_idle("rand_drain", (D + 2) * FRAME + 20);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
